// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam int          INST_W           = 32;
   localparam int          CNT_W            = 3;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
      logic              adef;
   } fetch_entry_t;

   localparam int FE_W = $bits(fetch_entry_t);

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_inst_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over push.
module if_inst_queue
   import if_stage_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [FE_W-1:0]  push_entry,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic [FE_W-1:0]  head
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

   logic [FE_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry storage; contents are only meaningful while count covers them.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC ownership, SRAM request issue, response
// bypass/buffering and branch redirect handling.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst,
   output logic        fs_to_ds_adef,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata
);

   logic [31:0]      fetch_pc;
   logic [31:0]      pend_pc;
   logic             pending;
   logic             pend_adef;
   logic             stale;
   logic             halted;

   logic [CNT_W-1:0] q_count;
   logic [FE_W-1:0]  q_head_raw;
   fetch_entry_t     q_head;
   fetch_entry_t     resp_entry;
   fetch_entry_t     offer;

   logic             q_nonempty;
   logic             resp_live;
   logic             pop;
   logic             q_pop;
   logic             bypass;
   logic             resp_push;
   logic [CNT_W:0]   occ;
   logic [31:0]      req_addr;
   logic             misaligned;
   logic             slot;

   // Offer selection, space accounting and request issue.
   always_comb begin
      q_nonempty = (q_count != '0);
      resp_live  = pending && !stale;
      q_head     = fetch_entry_t'(q_head_raw);

      // A misaligned fetch travels as a pseudo-response with no SRAM access.
      resp_entry.pc   = pend_pc;
      resp_entry.inst = pend_adef ? '0 : inst_sram_rdata;
      resp_entry.adef = pend_adef;

      offer = '0;
      if (q_nonempty)     offer = q_head;
      else if (resp_live) offer = resp_entry;

      fs_to_ds_valid = !br_taken && (q_nonempty || resp_live);
      fs_to_ds_pc    = offer.pc;
      fs_to_ds_inst  = offer.inst;
      fs_to_ds_adef  = offer.adef;

      pop       = fs_to_ds_valid && ds_allowin;
      q_pop     = pop && q_nonempty;
      bypass    = pop && !q_nonempty;
      resp_push = resp_live && !br_taken && !bypass;

      // Occupancy after this edge, counting the response now on rdata.
      if (br_taken) occ = '0;
      else          occ = {1'b0, q_count} + (CNT_W+1)'(resp_live) - (CNT_W+1)'(pop);

      req_addr   = br_taken ? br_target : fetch_pc;
      misaligned = is_misaligned(req_addr);
      slot       = !reset && (!halted || br_taken) && (occ < (CNT_W+1)'(QDEPTH));

      inst_sram_en    = slot && !misaligned;
      inst_sram_addr  = req_addr;
      inst_sram_we    = 4'h0;
      inst_sram_wdata = 32'h0;
   end

   // Fetch PC, in-flight tracking and halt on misaligned fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc  <= RESET_PC;
         pend_pc   <= '0;
         pending   <= 1'b0;
         pend_adef <= 1'b0;
         stale     <= 1'b0;
         halted    <= 1'b0;
      end else begin
         pending   <= slot;
         pend_adef <= slot && misaligned;
         if (slot) pend_pc <= req_addr;

         if (slot)          fetch_pc <= req_addr + 32'd4;
         else if (br_taken) fetch_pc <= br_target;

         // Redirect without a replacement request: nothing on rdata next
         // cycle belongs to the new path.
         stale <= br_taken && !slot;

         if (slot && misaligned) halted <= 1'b1;
         else if (br_taken)      halted <= 1'b0;
      end
   end

   if_inst_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (resp_push),
      .push_entry (resp_entry),
      .pop        (q_pop),
      .flush      (br_taken),
      .count      (q_count),
      .head       (q_head_raw)
   );

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage feeding the ID stage of the five-stage LoongArch pipeline. Owns the fetch PC, issues requests to the synchronous instruction SRAM, and buffers returned instructions in a small queue so ID stalls never lose SRAM read data. Handles branch redirects from ID, including cancelling in-flight fetches, and flags misaligned fetch addresses.

## Interface
- RESET_PC, 32'h1c00_0000, address of the first fetch after reset
- QDEPTH, 2, instruction queue entries; legal values 2..4
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- ds_allowin  in  1  ID can accept an instruction this cycle
- br_taken  in  1  redirect from ID; already qualified by ID valid/ready
- br_target  in  32  redirect address
- fs_to_ds_valid  out  1  {pc, inst, adef} offered to ID
- fs_to_ds_pc  out  32  PC of offered instruction
- fs_to_ds_inst  out  32  instruction word; 0 when adef
- fs_to_ds_adef  out  1  offered PC is not word aligned
- inst_sram_en  out  1  read request this cycle
- inst_sram_we  out  4  constant 0
- inst_sram_addr  out  32  request address
- inst_sram_wdata  out  32  constant 0
- inst_sram_rdata  in  32  data for the request of the previous cycle

## Operation
- State: fetch_pc (next address to request), pending (1 bit: request issued last cycle, data on rdata now), stale (pending response is cancelled), halted (misaligned fetch outstanding), queue of QDEPTH entries {pc, inst, adef}, count.
- Transfer to ID: fs_to_ds_valid && ds_allowin. Offered entry: queue head when count!=0; otherwise the live SRAM response (pending && !stale), bypassing the queue.
- Response arriving while not taken by bypass is enqueued. A response is never dropped except when stale or when br_taken is high.
- Issue: inst_sram_en = !reset && !halted && (count + pending - pop < QDEPTH), where pop = 1 if an entry leaves this cycle. inst_sram_addr = br_taken ? br_target : fetch_pc. On issue, fetch_pc <= inst_sram_addr + 4.
- Misaligned address (addr[1:0]!=0): no SRAM request; instead enqueue {addr, 32'h0, adef=1} (subject to the same space rule) and set halted. halted clears only on br_taken or reset.
- br_taken: queue cleared, pending response marked stale, halted cleared, fs_to_ds_valid forced 0 in that cycle; the redirect request uses br_target in the same cycle if space permits (queue is empty, so it does), else fetch_pc <= br_target.
- br_taken coinciding with an arriving response: response discarded.
- PC arithmetic modulo 2^32; fetch at 0xffff_fffc wraps to 0.

## Timing
- Reset values: fs_to_ds_valid 0, fs_to_ds_pc/inst 0, fs_to_ds_adef 0, inst_sram_en 0, fetch_pc RESET_PC, count 0, pending 0, stale 0, halted 0.
- First request in the first cycle with reset low, addr RESET_PC.
- Latency: request at cycle t -> instruction offered at t+1 (bypass, queue empty) -> ID capture at end of t+1 if ds_allowin.
- Steady-state throughput 1 instruction/cycle with ds_allowin held high.
- Redirect penalty: br_taken at t -> target request at t -> target offered at t+1.
- Reset asserted mid-operation: all state returns to reset values on the next edge; a response arriving in the cycle after reset is ignored (pending cleared).
- ID stall: at most QDEPTH instructions outstanding (queued + pending); inst_sram_en stays 0 until a pop frees space, then resumes the cycle of the pop.

## Structure
- Shared package: RESET_PC default, LoongArch instruction width constant, typedef for the fetch entry {pc[31:0], inst[31:0], adef}.
- One sub-module: if_inst_queue, a synchronous FIFO of fetch entries with push, pop, flush, count, head; flush has priority over push.
- Issue/bypass/redirect logic in if_stage itself.

## Test plan
- Reset release, ds_allowin=1, SRAM returns addr as data -> requests 0x1c000000, 0x1c000004, ... one per cycle; ID sees matching pc/inst from cycle 1.
- ds_allowin low for 5 cycles after stream start -> exactly 2 requests outstanding, en low while full, no instruction lost or duplicated after release.
- br_taken with target 0x1c000100 while one response in flight and queue holding 1 entry -> valid 0 that cycle, in-flight and queued dropped, next offered pc 0x1c000100.
- br_taken to 0x1c000102 -> no SRAM request, ID offered pc 0x1c000102, inst 0, adef 1; en stays 0 until next br_taken to 0x1c000200 resumes fetch.
- Reset asserted while queue full and request pending -> next cycle all outputs at reset values; after release fetch restarts at 0x1c000000.
- Fetch at 0xfffffffc -> next request address 0x00000000.
